// File: rtl/ddc_fifo_rd_sched_if.sv
// ---------------------------------------------------------------------------
// ddc_fifo_rd_sched_if
// Framed {I,Q} sample stream from the DDC read scheduler to the packetizer.
//
// Signals:
//   m_data   2*DATA_WIDTH  sample, {I, Q}, I in the MSBs
//   m_chan   1             channel of the sample (0 = L, 1 = R)
//   m_sof    1             first sample of a frame
//   m_eof    1             last sample of a frame
//   m_valid  1             sample valid
//   m_ready  1             downstream ready
//
// Modports:
//   master   scheduler side (drives data/flags/valid, samples ready)
//   slave    packetizer side
// ---------------------------------------------------------------------------
interface ddc_fifo_rd_sched_if #(
    parameter int DATA_WIDTH = 34
);
    logic [2*DATA_WIDTH-1:0] m_data;
    logic                    m_chan;
    logic                    m_sof;
    logic                    m_eof;
    logic                    m_valid;
    logic                    m_ready;

    modport master (
        output m_data,
        output m_chan,
        output m_sof,
        output m_eof,
        output m_valid,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_chan,
        input  m_sof,
        input  m_eof,
        input  m_valid,
        output m_ready
    );
endinterface

// File: rtl/ddc_fifo_rd_sched.sv
// ---------------------------------------------------------------------------
// ddc_fifo_rd_sched
// Read-side scheduler for the four DDC output FIFOs (L I/Q pair, R I/Q pair).
// Drains the L and R pairs in fixed-length frames, round-robin between the
// channels, and emits one framed {I,Q} stream with a valid/ready handshake.
// At most one sample is in flight at any time.
//
// Ports:
//   rd_clk              clock, rising edge
//   rst_n               synchronous active-low reset
//   enable              run enable, sampled only between frames
//   empty_L / empty_R   empty flags of the L_I / R_I FIFOs (Q FIFOs in lockstep)
//   rd_en_L / rd_en_R   registered read strobes to the L / R FIFO pairs
//   din_L_i .. din_R_q  FIFO dout buses, valid one cycle after rd_en
//   m                   output stream (ddc_fifo_rd_sched_if.master)
//   frame_cnt           completed-frame counter, wraps at 16 bits
// ---------------------------------------------------------------------------
module ddc_fifo_rd_sched #(
    parameter int DATA_WIDTH = 34,
    parameter int FRAME_LEN  = 16
) (
    input  logic                  rd_clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  empty_L,
    input  logic                  empty_R,
    output logic                  rd_en_L,
    output logic                  rd_en_R,
    input  logic [DATA_WIDTH-1:0] din_L_i,
    input  logic [DATA_WIDTH-1:0] din_L_q,
    input  logic [DATA_WIDTH-1:0] din_R_i,
    input  logic [DATA_WIDTH-1:0] din_R_q,
    ddc_fifo_rd_sched_if.master   m,
    output logic [15:0]           frame_cnt
);

    localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        RD,
        CAP,
        SEND
    } state_t;

    state_t      state;
    logic        last;
    logic [15:0] scnt;

    logic        other_empty;
    logic        pick_chan;
    logic        can_pick;
    logic        sel_empty;

    // Round-robin choice: prefer the channel not served last, fall back to
    // the same channel when the other one has nothing to offer.
    always_comb begin
        other_empty = last ? empty_L : empty_R;
        pick_chan   = other_empty ? last : ~last;
        can_pick    = !empty_L || !empty_R;
        sel_empty   = m.m_chan ? empty_R : empty_L;
    end

    // Main FSM. The read strobe is a register, so the decision to read is
    // taken on the edge that enters RD (and re-taken on every edge while RD
    // waits for data). RD therefore lasts exactly one cycle when the FIFO
    // has data: the cycle in which rd_en is high. A frame never changes
    // channel while waiting on an empty FIFO.
    always_ff @(posedge rd_clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            last      <= 1'b1;
            scnt      <= '0;
            rd_en_L   <= 1'b0;
            rd_en_R   <= 1'b0;
            m.m_valid <= 1'b0;
            m.m_sof   <= 1'b0;
            m.m_eof   <= 1'b0;
            m.m_chan  <= 1'b0;
            m.m_data  <= '0;
            frame_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= ARB;
                    end
                end

                ARB: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (can_pick) begin
                        m.m_chan <= pick_chan;
                        scnt     <= '0;
                        rd_en_L  <= !pick_chan;
                        rd_en_R  <= pick_chan;
                        state    <= RD;
                    end
                end

                RD: begin
                    if (rd_en_L || rd_en_R) begin
                        rd_en_L <= 1'b0;
                        rd_en_R <= 1'b0;
                        state   <= CAP;
                    end else begin
                        rd_en_L <= !m.m_chan && !sel_empty;
                        rd_en_R <= m.m_chan && !sel_empty;
                    end
                end

                CAP: begin
                    m.m_data  <= m.m_chan ? {din_R_i, din_R_q} : {din_L_i, din_L_q};
                    m.m_sof   <= (scnt == 16'd0);
                    m.m_eof   <= (scnt == LAST_IDX);
                    m.m_valid <= 1'b1;
                    state     <= SEND;
                end

                SEND: begin
                    if (m.m_ready) begin
                        m.m_valid <= 1'b0;
                        if (m.m_eof) begin
                            frame_cnt <= frame_cnt + 16'd1;
                            last      <= m.m_chan;
                            state     <= ARB;
                        end else begin
                            scnt    <= scnt + 16'd1;
                            rd_en_L <= !m.m_chan && !sel_empty;
                            rd_en_R <= m.m_chan && !sel_empty;
                            state   <= RD;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ddc_fifo_rd_sched.md
# ddc_fifo_rd_sched

Read-side scheduler for the four DDC output FIFOs: the L pair (I/Q) and the R pair (I/Q). It sits in the `rd_clk` domain and replaces the free-running `rd_en = ~rst` read strobe. It drains the L and R FIFO pairs in fixed-length frames, alternating between channels round-robin. Its output is one framed {I,Q} sample stream with a valid/ready handshake, feeding the downstream packetizer.

## Interface
- `DATA_WIDTH`, default 34: width of each I or Q sample.
- `FRAME_LEN`, default 16: samples per frame. Legal range 2..65535.
- `rd_clk`  in  1: the only clock. All logic is rising-edge.
- `rst_n`  in  1: reset, synchronous and active-low.
- `enable`  in  1: scheduler run enable.
- `empty_L`  in  1: empty flag of the L_I FIFO. The L_Q FIFO is written in lockstep with it.
- `empty_R`  in  1: empty flag of the R_I FIFO. The R_Q FIFO is written in lockstep with it.
- `rd_en_L`  out  1: read strobe to both L FIFOs.
- `rd_en_R`  out  1: read strobe to both R FIFOs.
- `din_L_i`, `din_L_q`, `din_R_i`, `din_R_q`  in  DATA_WIDTH each: FIFO `dout` buses. Valid one cycle after the matching `rd_en`.
- `m_data`  out  2*DATA_WIDTH: output sample, packed {I, Q} with I in the MSBs.
- `m_chan`  out  1: channel of the output sample. 0 = L, 1 = R.
- `m_sof`  out  1: marks the first sample of a frame.
- `m_eof`  out  1: marks the last sample of a frame.
- `m_valid`  out  1: output valid.
- `m_ready`  in  1: downstream ready.
- `frame_cnt`  out  16: count of completed frames. Wraps at 65535 → 0.

## Operation
- FSM states: IDLE, ARB, RD, CAP, SEND.
- **IDLE**
  - Go to ARB when `enable`=1.
- **ARB**
  - Let `last` be the channel served by the previous frame. After reset, `last` = R, so L has priority first.
  - Select the channel other than `last` if its FIFO is non-empty. Otherwise select `last` if its FIFO is non-empty.
  - If both FIFOs are empty, stay in ARB.
  - If `enable`=0, go to IDLE.
  - Once a channel is selected: latch it into `m_chan`, clear the sample counter `scnt` to 0, go to RD.
- **RD**
  - If the selected FIFO is non-empty: assert its `rd_en` for exactly this cycle, go to CAP.
  - If it is empty: stay in RD with `rd_en` low. A frame never switches channel mid-frame.
- **CAP**
  - Register the selected `din_*_i` / `din_*_q` into `m_data`.
  - Set `m_sof` = (`scnt`==0) and `m_eof` = (`scnt`==FRAME_LEN-1).
  - Go to SEND.
- **SEND**
  - Hold `m_valid`=1. `m_data`, `m_chan`, `m_sof`, `m_eof` stay stable until the handshake.
  - On `m_valid && m_ready`:
    - If not eof: increment `scnt`, go to RD.
    - If eof: increment `frame_cnt`, set `last` to the current channel, go to ARB.
- `enable` is sampled only in IDLE and ARB. Deasserting it mid-frame lets the frame complete, then the FSM parks in IDLE.
- `rd_en_L` and `rd_en_R` are never high in the same cycle. Neither is ever high while its own empty flag is high.
- At most one sample is in flight. `rd_en` is never asserted while in CAP or SEND.

## Timing
- Reset (`rst_n`=0 at a rising edge) takes effect on that edge, in any state:
  - FSM → IDLE, `scnt`=0, `last`=R.
  - Outputs: `rd_en_L`=0, `rd_en_R`=0, `m_valid`=0, `m_sof`=0, `m_eof`=0, `m_chan`=0, `m_data`=0, `frame_cnt`=0.
  - A sample already read from a FIFO and not yet transferred is discarded.
- `rd_en_*` is registered. It is high during the RD cycle and low in every other state.
- Read latency: `rd_en` in cycle t → data captured at the end of t+1 (CAP) → `m_valid`=1 from cycle t+2.
- Minimum cost per sample is 3 cycles (RD, CAP, SEND with `m_ready`=1).
- Minimum frame time is 1 ARB cycle + 3×FRAME_LEN cycles.
- Back-pressure: `m_ready` may be low for any number of cycles. No FIFO reads occur during the stall.
- The `frame_cnt` update is visible the cycle after the eof handshake.

## Test plan
- **Reset:** hold `rst_n`=0 with both FIFOs non-empty and `enable`=1 → all outputs 0, no `rd_en` pulse. Release `rst_n` → first frame is L.
- **Single-channel frame:** L FIFO preloaded with 16 samples (values 1..16), R empty, `m_ready`=1 →
  - 16 transfers with `m_chan`=0.
  - `m_sof` on value 1, `m_eof` on value 16.
  - Exactly 16 `rd_en_L` pulses, spaced 3 cycles apart.
  - `frame_cnt`=1. FSM ends in ARB.
- **Round-robin:** both FIFOs hold 48 samples →
  - Frames come out in channel order L, R, L, R, L, R.
  - `frame_cnt`=6.
  - `rd_en_L` and `rd_en_R` are never high together.
- **Back-pressure:** drop `m_ready` for 10 cycles at sample 5 of a frame → `m_data`, `m_sof`/`m_eof`, `m_valid` held constant, zero `rd_en` pulses during the stall. The frame then completes normally.
- **Underflow mid-frame:** L frame with `empty_L` raised after sample 7 for 20 cycles, R non-empty throughout → no `rd_en_L` while empty, no R read. The L frame resumes, ends with `m_eof` on sample 16, then the next frame is R.
- **Enable drop and reset mid-frame:**
  - Deassert `enable` at sample 3 → frame finishes with eof, FSM goes to IDLE, no further reads.
  - Re-enable and assert `rst_n`=0 during a SEND → next cycle `m_valid`=0 and `frame_cnt`=0.
